line_slot_scheduler: RTL and testbench

//  Sequences the 128-entry x 384-bit line BRAM shared by the video input writer and the CPS reader.

---
 rtl/line_slot_scheduler.sv | 123 ++++++++++++
 tb/tb_line_slot_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/line_slot_scheduler.sv
// Line slot scheduler: hands out write/read slots of a shared line BRAM.
// Optional drop statistics counter enabled by defining SLOT_STATS_EN.
module line_slot_scheduler #(
   parameter int ADDR_W     = 7,
   parameter int SLOTS      = 4,
   parameter int SLOT_DEPTH = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     frame_i,
   input  logic                     wr_req_i,
   input  logic                     wr_done_i,
   output logic                     wr_gnt_o,
   output logic [ADDR_W-1:0]        wr_base_o,
   output logic                     wr_drop_o,
   input  logic                     rd_req_i,
   input  logic                     rd_done_i,
   output logic                     rd_gnt_o,
   output logic [ADDR_W-1:0]        rd_base_o,
   output logic [$clog2(SLOTS):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
`ifdef SLOT_STATS_EN
   ,
   output logic [15:0]              drop_cnt_o
`endif
);

   localparam int PW = $clog2(SLOTS);
   localparam int SW = $clog2(SLOT_DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic {W_IDLE, W_ACTIVE} w_state_t;
   typedef enum logic {R_IDLE, R_ACTIVE} r_state_t;

   w_state_t        w_state;
   r_state_t        r_state;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            w_commit;
   logic            r_release;
   logic            drop_now;

   assign full_o    = (level_o == LW'(SLOTS));
   assign empty_o   = (level_o == '0);
   assign w_commit  = (w_state == W_ACTIVE) && wr_done_i;
   assign r_release = (r_state == R_ACTIVE) && rd_done_i;
   assign drop_now  = wr_req_i && ((w_state == W_ACTIVE) || full_o);

   // Write/read FSMs, pointers, occupancy level and registered pulses
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         w_state   <= W_IDLE;
         r_state   <= R_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level_o   <= '0;
         wr_gnt_o  <= 1'b0;
         rd_gnt_o  <= 1'b0;
         wr_drop_o <= 1'b0;
         wr_base_o <= '0;
         rd_base_o <= '0;
      end else if (frame_i) begin
         w_state   <= W_IDLE;
         r_state   <= R_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level_o   <= '0;
         wr_gnt_o  <= 1'b0;
         rd_gnt_o  <= 1'b0;
         wr_drop_o <= 1'b0;
      end else begin
         wr_gnt_o  <= 1'b0;
         rd_gnt_o  <= 1'b0;
         wr_drop_o <= drop_now;
         case (w_state)
            W_IDLE: begin
               if (wr_req_i && !full_o) begin
                  wr_gnt_o  <= 1'b1;
                  wr_base_o <= {wr_ptr, SW'(0)};
                  w_state   <= W_ACTIVE;
               end
            end
            W_ACTIVE: begin
               if (wr_done_i) begin
                  wr_ptr  <= wr_ptr + 1'b1;
                  w_state <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
         case (r_state)
            R_IDLE: begin
               if (rd_req_i && !empty_o) begin
                  rd_gnt_o  <= 1'b1;
                  rd_base_o <= {rd_ptr, SW'(0)};
                  r_state   <= R_ACTIVE;
               end
            end
            R_ACTIVE: begin
               if (rd_done_i) begin
                  rd_ptr  <= rd_ptr + 1'b1;
                  r_state <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
         level_o <= level_o + LW'(w_commit) - LW'(r_release);
      end
   end

`ifdef SLOT_STATS_EN
   // Saturating count of rejected write requests since reset/frame
   always_ff @(posedge clk_i) begin
      if (!rst_i || frame_i) begin
         drop_cnt_o <= '0;
      end else if (drop_now && drop_cnt_o != 16'hFFFF) begin
         drop_cnt_o <= drop_cnt_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_line_slot_scheduler.sv
// Testbench for line_slot_scheduler: directed scenarios plus random
// stimulus checked every cycle against a slot-queue reference model.
module tb_line_slot_scheduler;

   localparam int ADDR_W = 7;
   localparam int SLOTS  = 4;
   localparam int DEPTH  = 32;

   logic clk = 0;
   logic rst = 0;
   logic frame = 0;
   logic wreq = 0;
   logic wdone = 0;
   logic rreq = 0;
   logic rdone = 0;
   logic wr_gnt, wr_drop, rd_gnt, full, empty;
   logic [ADDR_W-1:0] wr_base, rd_base;
   logic [2:0] level;
`ifdef SLOT_STATS_EN
   logic [15:0] drop_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: committed slots wait in a queue; the reader
   // holds one slot (still counted) until it releases it
   int q[$];
   bit busy_w, busy_r;
   int wcnt;
   int e_wbase, e_rbase, e_dc;
   bit e_wg, e_rg, e_dr;

   always #5 clk = ~clk;

   line_slot_scheduler #(
      .ADDR_W(ADDR_W), .SLOTS(SLOTS), .SLOT_DEPTH(DEPTH)
   ) dut (
      .clk_i(clk), .rst_i(rst), .frame_i(frame),
      .wr_req_i(wreq), .wr_done_i(wdone),
      .wr_gnt_o(wr_gnt), .wr_base_o(wr_base), .wr_drop_o(wr_drop),
      .rd_req_i(rreq), .rd_done_i(rdone),
      .rd_gnt_o(rd_gnt), .rd_base_o(rd_base),
      .level_o(level), .full_o(full), .empty_o(empty)
`ifdef SLOT_STATS_EN
      , .drop_cnt_o(drop_cnt)
`endif
   );

   task automatic chk(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic int mlevel();
      return q.size() + (busy_r ? 1 : 0);
   endfunction

   task automatic model_step();
      int lvl;
      bit ow, orr;
      lvl = mlevel();
      ow = busy_w;
      orr = busy_r;
      e_wg = 0; e_rg = 0; e_dr = 0;
      if (!rst) begin
         q.delete(); busy_w = 0; busy_r = 0; wcnt = 0;
         e_wbase = 0; e_rbase = 0; e_dc = 0;
      end else if (frame) begin
         q.delete(); busy_w = 0; busy_r = 0; wcnt = 0; e_dc = 0;
      end else begin
         if (wreq) begin
            if (!ow && lvl < SLOTS) begin
               e_wg = 1;
               e_wbase = (wcnt % SLOTS) * DEPTH;
               busy_w = 1;
            end else begin
               e_dr = 1;
               if (e_dc < 65535) e_dc++;
            end
         end
         if (!orr && rreq && lvl > 0) begin
            e_rg = 1;
            e_rbase = q.pop_front() * DEPTH;
            busy_r = 1;
         end
         if (ow && wdone) begin
            q.push_back(wcnt % SLOTS);
            wcnt++;
            busy_w = 0;
         end
         if (orr && rdone) busy_r = 0;
      end
   endtask

   task automatic compare();
      int l;
      l = mlevel();
      chk("wr_gnt", wr_gnt, e_wg);
      chk("wr_drop", wr_drop, e_dr);
      chk("rd_gnt", rd_gnt, e_rg);
      chk("wr_base", wr_base, e_wbase);
      chk("rd_base", rd_base, e_rbase);
      chk("level", level, l);
      chk("full", full, l == SLOTS);
      chk("empty", empty, l == 0);
`ifdef SLOT_STATS_EN
      chk("drop_cnt", drop_cnt, e_dc);
`endif
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      compare();
   endtask

   task automatic pulse_w();
      wreq = 1; cyc(); wreq = 0;
   endtask

   task automatic pulse_wd();
      wdone = 1; cyc(); wdone = 0;
   endtask

   task automatic do_frame();
      frame = 1; cyc(); frame = 0;
   endtask

   initial begin
      cyc(); cyc();
      rst = 1;
      for (int i = 0; i < 10; i++) cyc();
      chk("idle_level", level, 0);
      chk("idle_empty", empty, 1);
      chk("idle_full", full, 0);
      chk("idle_pulses", {wr_gnt, rd_gnt, wr_drop}, 0);

      pulse_w();
      chk("t2_wgnt", wr_gnt, 1);
      chk("t2_wbase", wr_base, 0);
      pulse_wd();
      chk("t2_level1", level, 1);
      rreq = 1; cyc(); rreq = 0;
      chk("t2_rgnt", rd_gnt, 1);
      chk("t2_rbase", rd_base, 0);
      rdone = 1; cyc(); rdone = 0;
      chk("t2_level0", level, 0);

      do_frame();
      for (int i = 0; i < 4; i++) begin
         pulse_w();
         chk("t3_wbase", wr_base, i * 32);
         pulse_wd();
      end
      chk("t3_full", full, 1);
      chk("t3_level4", level, 4);
      for (int k = 0; k < 3; k++) begin
         pulse_w();
         chk("t3_drop", wr_drop, 1);
         chk("t3_lvl", level, 4);
      end
`ifdef SLOT_STATS_EN
      chk("t3_dcnt3", drop_cnt, 3);
`endif
      do_frame();
      chk("t3_flush", level, 0);
`ifdef SLOT_STATS_EN
      chk("t3_dcnt0", drop_cnt, 0);
`endif

      pulse_w(); pulse_wd();
      pulse_w(); pulse_wd();
      rreq = 1; cyc(); rreq = 0;
      pulse_w();
      chk("t4_wbase", wr_base, 64);
      wdone = 1; rdone = 1; cyc(); wdone = 0; rdone = 0;
      chk("t4_level2", level, 2);
      rreq = 1; cyc(); rreq = 0;
      chk("t4_rbase", rd_base, 32);
      pulse_w();
      chk("t4_wbase2", wr_base, 96);
      pulse_wd();

      do_frame();
      for (int i = 0; i < 3; i++) begin
         pulse_w(); pulse_wd();
      end
      pulse_w();
      chk("t5_wbase", wr_base, 96);
      do_frame();
      chk("t5_level", level, 0);
      chk("t5_empty", empty, 1);
      pulse_w();
      chk("t5_wbase0", wr_base, 0);
      pulse_wd();

      for (int i = 0; i < 4000; i++) begin
         wreq  = ($urandom_range(3) == 0);
         wdone = ($urandom_range(2) == 0);
         rdone = ($urandom_range(2) == 0);
         frame = ($urandom_range(79) == 0);
         rst   = ($urandom_range(299) != 0);
         if (e_rg) rreq = 0;
         else if (!rreq) rreq = ($urandom_range(2) == 0);
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
